// File: rtl/tx_serial_out.sv
// -----------------------------------------------------------------------------
// tx_serial_out
//   Console back end for the CPU's 7-bit character output. Every rising edge
//   with a non-zero character is a push into a small circular FIFO. Queued
//   characters are sent as UART frames: one start bit, 7 data bits LSB first,
//   one stop bit, no parity. The producer is never stalled. A character that
//   arrives while the FIFO is full (and no pop frees a slot on that edge) is
//   dropped, and the sticky overflow flag is set.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   char_in    : character from the CPU; 7'h00 means idle
//   serial_out : UART line, idle high, registered
//   busy       : high while a frame is on the line, registered
//   fifo_count : queued characters, excluding the one being shifted
//   overflow   : sticky, set when a character is dropped
// -----------------------------------------------------------------------------
module tx_serial_out #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             char_in,
    output logic                   serial_out,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [BAUD_W-1:0]  baud, baud_n;
    logic [2:0]         idx, idx_n;
    logic [6:0]         shift;
    logic [6:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic               push, pop, accept;
    logic               serial_n, busy_n;
    logic               baud_end, have_data;

    assign push      = (char_in != 7'h00);
    assign baud_end  = (baud == BAUD_LAST);
    assign have_data = (fifo_count != '0);
    // A full FIFO still takes a character when the same edge pops one.
    assign accept    = push && ((fifo_count != FULL_CNT) || pop);

    always_comb begin
        state_n = state;
        baud_n  = baud;
        idx_n   = idx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    state_n = START;
                    baud_n  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                    baud_n  = '0;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (idx == 3'd6) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more is queued.
                    if (have_data) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is derived from the next state so the output flop
        // changes on the same edge as the state, keeping it glitch-free.
        // DATA is only entered from START, so shift is already loaded.
        serial_n = (state_n == DATA) ? shift[idx_n] : (state_n != START);
        busy_n   = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud       <= '0;
            idx        <= 3'd0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            idx        <= idx_n;
            serial_out <= serial_n;
            busy       <= busy_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !accept) overflow <= 1'b1;
        end
    end

    // Storage and shift register carry data only; their contents after
    // reset are never observed before being written.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= char_in;
        if (pop)    shift     <= mem[rptr];
    end

endmodule

// File: tb/tb_tx_serial_out.sv
module tb_tx_serial_out;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
    localparam int FLEN  = 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] char_in;
    logic       serial_out;
    logic       busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    tx_serial_out #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .serial_out (serial_out),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue + frame position -------------
    int q[$];
    int popped[$];
    bit m_act;
    int m_pos;
    int m_cur;
    bit m_ovf;
    bit m_pop, m_acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete(); popped.delete();
            m_act = 0; m_pos = 0; m_cur = 0; m_ovf = 0;
        end else begin
            m_pop = (q.size() > 0) && (!m_act || m_pos == FLEN - 1);
            m_acc = (char_in != 0) && (q.size() < DEPTH || m_pop);
            if (char_in != 0 && !m_acc) m_ovf = 1;
            if (m_pop) begin
                m_cur = q.pop_front();
                popped.push_back(m_cur);
                m_act = 1;
                m_pos = 0;
            end else if (m_act) begin
                if (m_pos == FLEN - 1) m_act = 0;
                else m_pos++;
            end
            if (m_acc) q.push_back(int'(char_in));
        end
    end

    function automatic bit exp_line();
        if (!m_act) return 1'b1;
        if (m_pos < CPB) return 1'b0;
        if (m_pos >= 8 * CPB) return 1'b1;
        return 1'((m_cur >> (m_pos / CPB - 1)) & 1);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("serial_out", 32'(serial_out), 32'(exp_line()));
            check("busy", 32'(busy), 32'(m_act));
            check("fifo_count", 32'(fifo_count), 32'(q.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // ---------------- line decoder (mid-bit sampling) ----------------------
    int dec_log[$];
    bit d_in;
    int d_cnt;
    int d_val;
    int d_exp;

    always @(negedge clk) begin
        if (!reset) begin
            d_in = 0; d_cnt = 0; d_val = 0;
        end else if (!d_in) begin
            if (serial_out == 1'b0) begin
                d_in = 1; d_cnt = 0; d_val = 0;
            end
        end else begin
            d_cnt++;
            if ((d_cnt % CPB) == CPB / 2 && d_cnt / CPB >= 1 && d_cnt / CPB <= 7)
                d_val = d_val | (int'(serial_out) << (d_cnt / CPB - 1));
            if (d_cnt == FLEN - 1) begin
                d_in = 0;
                dec_log.push_back(d_val);
                if (popped.size() == 0) begin
                    check("decode_unexpected", 32'(d_val), 32'hFFFF);
                end else begin
                    d_exp = popped.pop_front();
                    check("decode_order", 32'(d_val), 32'(d_exp));
                end
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    // Value v is sampled at the next rising edge; returns 2 time units after it.
    task automatic step(input logic [6:0] v);
        char_in = v;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(7'h00);
    endtask

    task automatic do_reset();
        char_in = 7'h00;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        dec_log.delete();
    endtask

    initial begin
        logic [6:0] ch;
        logic [6:0] sent[$];
        int pct;
        bit e;

        reset = 1'b1;
        char_in = 7'h00;
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_serial", 32'(serial_out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        do_reset();

        // 1: single 0x41 frame, literal waveform
        ch = 7'h41;
        step(ch);
        check("t1_cnt_e0", 32'(fifo_count), 32'd1);
        check("t1_line_e0", 32'(serial_out), 32'd1);
        step(7'h00);
        check("t1_cnt_e1", 32'(fifo_count), 32'd0);
        check("t1_line_c1", 32'(serial_out), 32'd0);
        check("t1_busy_c1", 32'(busy), 32'd1);
        for (int c = 2; c <= 37; c++) begin
            step(7'h00);
            if (c <= 4)       e = 1'b0;
            else if (c <= 32) e = ch[(c - 5) / 4];
            else              e = 1'b1;
            check($sformatf("t1_line_c%0d", c), 32'(serial_out), 32'(e));
            if (c == 36) check("t1_busy_c36", 32'(busy), 32'd1);
            if (c == 37) check("t1_busy_c37", 32'(busy), 32'd0);
        end
        check("t1_decoded_n", 32'(dec_log.size()), 32'd1);
        if (dec_log.size() > 0) check("t1_decoded", 32'(dec_log[0]), 32'h41);

        // 2: back-to-back frames, no idle gap
        do_reset();
        step(7'h48);
        step(7'h69);
        idle(35);
        check("t2_c36_stop", 32'(serial_out), 32'd1);
        step(7'h00);
        check("t2_c37_start", 32'(serial_out), 32'd0);
        check("t2_c37_busy", 32'(busy), 32'd1);
        idle(40);
        check("t2_decoded_n", 32'(dec_log.size()), 32'd2);
        if (dec_log.size() == 2) begin
            check("t2_byte0", 32'(dec_log[0]), 32'h48);
            check("t2_byte1", 32'(dec_log[1]), 32'h69);
        end

        // 3: held character overflows the FIFO
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) step(7'h2A);
        check("t3_count_full", 32'(fifo_count), 32'(DEPTH));
        check("t3_ovf", 32'(overflow), 32'd1);
        idle((DEPTH + 1) * FLEN + 10);
        check("t3_frames", 32'(dec_log.size()), 32'(DEPTH + 1));
        for (int i = 0; i < dec_log.size(); i++)
            check("t3_byte", 32'(dec_log[i]), 32'h2A);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: push while full on the STOP-end pop edge
        do_reset();
        for (int i = 0; i <= DEPTH; i++) step(7'(8'h31 + i));
        check("t4_count_full", 32'(fifo_count), 32'(DEPTH));
        check("t4_ovf_pre", 32'(overflow), 32'd0);
        idle(37 - (DEPTH + 1));
        step(7'h5A);
        check("t4_count_kept", 32'(fifo_count), 32'(DEPTH));
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_next_start", 32'(serial_out), 32'd0);
        idle((DEPTH + 1) * FLEN + 10);
        check("t4_frames", 32'(dec_log.size()), 32'(DEPTH + 2));
        if (dec_log.size() == DEPTH + 2)
            check("t4_last", 32'(dec_log[DEPTH + 1]), 32'h5A);

        // 5: asynchronous reset mid-DATA
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) step(7'h55);
        check("t5_pre_low", 32'(serial_out), 32'd0);
        check("t5_pre_ovf", 32'(overflow), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("t5_serial", 32'(serial_out), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        char_in = 7'h00;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        dec_log.delete();
        idle(60);
        check("t5_quiet_frames", 32'(dec_log.size()), 32'd0);
        check("t5_quiet_busy", 32'(busy), 32'd0);

        // 6: 20 spaced characters, pointer wrap
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ch = 7'($urandom_range(1, 127));
            sent.push_back(ch);
            step(ch);
            idle(FLEN - 1);
        end
        idle(FLEN + 4);
        check("t6_frames", 32'(dec_log.size()), 32'd20);
        for (int i = 0; i < 20 && i < dec_log.size(); i++)
            check($sformatf("t6_byte%0d", i), 32'(dec_log[i]), 32'(sent[i]));
        check("t6_ovf", 32'(overflow), 32'd0);

        // random traffic with varying density, model-checked every cycle
        do_reset();
        for (int blk = 0; blk < 16; blk++) begin
            pct = (blk % 4 == 0) ? 2 : (blk % 4 == 1) ? 10 : (blk % 4 == 2) ? 40 : 90;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 99) < pct) step(7'($urandom_range(1, 127)));
                else step(7'h00);
            end
        end
        idle((DEPTH + 2) * FLEN);
        check("rand_drained", 32'(fifo_count), 32'd0);
        check("rand_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tx_serial_out.md
Name: tx_serial_out

Overview:
- Downstream consumer of the CPU's 7-bit character output `tx`.
- Captures each non-zero character the CPU presents and queues it in a small FIFO.
- Serializes queued characters as asynchronous UART frames: 1 start bit, 7 data bits LSB first, 1 stop bit, no parity.
- Gives the core a physical one-wire console; the core never stalls.

Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- CLKS_PER_BIT, 4: clk cycles per serial bit; ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- char_in  input  7  character from the CPU's `tx`; 7'h00 means idle, any non-zero value is a character.
- serial_out  output  1  UART line; idle high.
- busy  output  1  high while a frame is in progress (state != IDLE).
- fifo_count  output  $clog2(DEPTH)+1  number of queued characters, not counting the one being shifted.
- overflow  output  1  sticky; set when a character is dropped because the FIFO is full.

Behaviour:
- Reset (reset==0, asynchronous, applies mid-frame too):
  - serial_out=1, busy=0, fifo_count=0, overflow=0, state=IDLE.
  - FIFO pointers and baud/bit counters are cleared.
  - FIFO contents are don't-care.
- Capture:
  - Every rising edge where char_in != 0 is one push.
  - A value held non-zero for k cycles pushes k copies. Deduplication is the producer's job.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - fifo_count = writes − reads.
  - Push when full with no pop in the same cycle: the character is dropped, overflow←1, contents unchanged.
  - Push and pop in the same cycle when full: both take effect, count stays DEPTH, overflow is not set.
  - Push and pop in the same cycle when empty: impossible, because a pop requires count>0 at the edge.
  - overflow clears only on reset.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1, plus a 3-bit data-bit index.
  - IDLE:
    - serial_out=1.
    - At an edge with fifo_count>0: pop the head into the shift register, baud←0, go to START.
    - A character pushed at edge N reaches IDLE-visible count at N, is popped at N+1, and serial_out falls after edge N+1.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA with index=0.
  - DATA:
    - serial_out = shift[index] for CLKS_PER_BIT cycles each.
    - index increments 0..6; after bit 6 go to STOP.
  - STOP:
    - serial_out=1 for CLKS_PER_BIT cycles.
    - At the final edge, if fifo_count>0: pop and go directly to START, with no idle gap between frames. Otherwise go to IDLE.
- Frame length is exactly 9·CLKS_PER_BIT cycles, start-bit first cycle to stop-bit last cycle.
- serial_out and busy are registered and glitch-free.
- serial_out changes only at bit boundaries.

Test Plan:
1. Reset, then char_in=7'h41 for one cycle at edge 0 (CLKS_PER_BIT=4) -> serial_out low cycles 1–4. Data bits 1,0,0,0,0,0,1 in cycles 5–32. High cycles 33–36. busy high cycles 1–36. fifo_count 1 after edge 0, 0 after edge 1.
2. Push 7'h48 and 7'h69 on consecutive edges -> two frames back-to-back. Second start bit begins the cycle immediately after the first stop bit, with no idle cycle. Decoded bytes are 0x48, 0x69.
3. Hold char_in=7'h2A for DEPTH+3 cycles while the first frame starts -> count saturates at DEPTH. overflow=1. Exactly DEPTH+1 frames of 0x2A are emitted (one popped early).
4. FIFO full, with a push on the same edge as the STOP-end pop -> new character accepted, fifo_count remains DEPTH, overflow stays 0.
5. Assert reset in the middle of the DATA state of frame 1 -> serial_out=1 immediately with no clock. busy=0, fifo_count=0, overflow=0. No output after release until a new push.
6. Push 20 characters spaced one frame apart with DEPTH=8 -> pointer wrap exercised. All 20 decoded in order, overflow=0.
